mcu_bus_tx: RTL

FPGA-to-MCU transmitter for the 8-bit parallel MCU bus. It accepts bytes tagged with a command/data flag from internal logic, buffers them in a small FIFO, and drives `bus`, `command_data` and a generated `busclk` strobe. Setup, high and hold intervals are counted in `sysclk` cycles and sized to satisfy the existing `sysclk`-oversampling bus receiver. It sits beside the receiver in the MCU bus interface; the top level owns the tristate on `bus` using `bus_out`/`bus_oe`.

---
 rtl/mcu_bus_pkg.sv | 29 ++
 rtl/mcu_bus_tx_if.sv | 26 ++
 rtl/mcu_bus_fifo.sv | 57 +++++
 rtl/mcu_bus_tx.sv | 119 +++++++++++
 4 files changed

// File: rtl/mcu_bus_pkg.sv
// Shared types and constants for the FPGA-to-MCU parallel bus transmitter.
// The receiver-derived constants bound how short the busclk high phase may be.
package mcu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        HIGH,
        HOLD
    } tx_state_e;

    localparam int DEF_SETUP_CYCLES = 4;
    localparam int DEF_HIGH_CYCLES  = 20;
    localparam int DEF_LOW_CYCLES   = 8;
    localparam int DEF_FIFO_DEPTH   = 4;

    // The receiver synchronises busclk and then waits before sampling bus.
    localparam int RX_SYNC_STAGES   = 3;
    localparam int RX_SAMPLE_DELAY  = 14;

    localparam int ENTRY_W          = 9;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mcu_bus_tx_if.sv
// Byte stream in from internal logic and bus-side outputs of the transmitter.
// The master side feeds bytes and the grant; the slave side is the transmitter.
interface mcu_bus_tx_if;

    logic [7:0] in_data;
    logic       in_cd;
    logic       in_valid;
    logic       in_ready;
    logic       tx_enable;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       command_data;
    logic       busclk;
    logic       busy;

    modport master (
        output in_data, in_cd, in_valid, tx_enable,
        input  in_ready, bus_out, bus_oe, command_data, busclk, busy
    );

    modport slave (
        input  in_data, in_cd, in_valid, tx_enable,
        output in_ready, bus_out, bus_oe, command_data, busclk, busy
    );

endinterface

// File: rtl/mcu_bus_fifo.sv
// Small synchronous FIFO with registered occupancy count.
// Read data is the head entry, valid whenever the FIFO is not empty.
module mcu_bus_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_depth_check
        $error("mcu_bus_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/mcu_bus_tx.sv
// FPGA-to-MCU transmitter: buffers tagged bytes and strobes each one onto the
// parallel bus with counted setup, high and hold phases of busclk.
module mcu_bus_tx
    import mcu_bus_pkg::*;
#(
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int HIGH_CYCLES  = DEF_HIGH_CYCLES,
    parameter int LOW_CYCLES   = DEF_LOW_CYCLES,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic        sysclk,
    input  logic        reset,
    mcu_bus_tx_if.slave bus_if
);

    localparam int CNT_MAX = max3(SETUP_CYCLES, HIGH_CYCLES, LOW_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_HIGH  = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_LOW   = CNT_W'(LOW_CYCLES - 1);

    if (HIGH_CYCLES < RX_SYNC_STAGES + RX_SAMPLE_DELAY + 1) begin : g_high_check
        $error("mcu_bus_tx: HIGH_CYCLES too short for the bus receiver");
    end
    if (SETUP_CYCLES < 1 || LOW_CYCLES < 1) begin : g_phase_check
        $error("mcu_bus_tx: SETUP_CYCLES and LOW_CYCLES must be at least 1");
    end

    tx_state_e                 state, state_nxt;
    logic [CNT_W-1:0]          cnt, cnt_nxt;
    logic                      pop;
    logic                      push;
    logic [ENTRY_W-1:0]        fifo_rd;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                      busclk_q;
    logic                      bus_oe_q;
    logic [7:0]                bus_out_q;
    logic                      cd_q;

    assign push = bus_if.in_valid && !fifo_full;

    mcu_bus_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sysclk),
        .rst     (reset),
        .push    (push),
        .pop     (pop),
        .wr_data ({bus_if.in_cd, bus_if.in_data}),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // The counter is reloaded on every state entry; zero marks the last cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = cnt;
                if (!fifo_empty && bus_if.tx_enable) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                    cnt_nxt   = LD_SETUP;
                end
            end
            SETUP: if (cnt == '0) begin
                state_nxt = HIGH;
                cnt_nxt   = LD_HIGH;
            end
            HIGH: if (cnt == '0) begin
                state_nxt = HOLD;
                cnt_nxt   = LD_LOW;
            end
            HOLD: if (cnt == '0) begin
                if (!fifo_empty && bus_if.tx_enable) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                    cnt_nxt   = LD_SETUP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobe and enable are registered from the next state so they never glitch.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            busclk_q  <= 1'b0;
            bus_oe_q  <= 1'b0;
            bus_out_q <= 8'h00;
            cd_q      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            busclk_q <= (state_nxt == HIGH);
            bus_oe_q <= (state_nxt != IDLE);
            if (pop) {cd_q, bus_out_q} <= fifo_rd;
        end
    end

    assign bus_if.in_ready     = !fifo_full;
    assign bus_if.busy         = (state != IDLE) || !fifo_empty;
    assign bus_if.busclk       = busclk_q;
    assign bus_if.bus_oe       = bus_oe_q;
    assign bus_if.bus_out      = bus_out_q;
    assign bus_if.command_data = cd_q;

endmodule
